// File: rtl/cword_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cword_pkg                                                    |
// | Description : Control-word field positions, microcode address layout and   |
// |               sequencer state encoding shared by sequencer and splitter.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package cword_pkg;

    // Control-word field positions
    localparam int c_out_lsb          = 0;
    localparam int c_out_msb          = 3;
    localparam int c_load_lsb         = 4;
    localparam int c_load_msb         = 7;
    localparam int c_alu_lsb          = 8;
    localparam int c_alu_msb          = 15;
    localparam int c_addrout_lsb      = 16;
    localparam int c_addrout_msb      = 18;
    localparam int c_addrload_lsb     = 19;
    localparam int c_addrload_msb     = 21;
    localparam int c_bit_sinc         = 22;
    localparam int c_bit_sdec         = 23;
    localparam int c_bit_step_resetn  = 24;
    localparam int c_bit_step_extn    = 25;
    localparam int c_bit_halt         = 26;
    localparam int c_bit_brk          = 27;
    localparam int c_bit_acalc_signed = 28;

    // Microcode address is {ext, opcode, step, byte_sel}
    localparam int c_sel_w         = 2;
    localparam int c_addr_overhead = 1 + c_sel_w;
    localparam int c_bytes_per_cw  = 4;

    // Fetch runs four read cycles plus one cycle to capture the last byte
    localparam logic [2:0] c_fetch_last = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_BREAK = 3'd3,
        S_HALT  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cword_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : cword_sequencer_if                                           |
// | Description : Instruction, microcode-memory and datapath signals of the    |
// |               control-word sequencer.                                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface cword_sequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int STEP_W   = 3,
    parameter int ADDR_W   = OPCODE_W + STEP_W + 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                start;
    logic                resume;
    logic                rom_rd;
    logic [ADDR_W-1:0]   rom_addr;
    logic [7:0]          rom_data;
    logic [31:0]         control_word;
    logic                cw_valid;
    logic                cw_ack;
    logic [STEP_W-1:0]   step;
    logic                busy;
    logic                halted;
    logic                brk;
    logic                overrun;

    modport master (
        input  opcode, start, resume, rom_data, cw_ack,
        output rom_rd, rom_addr, control_word, cw_valid, step, busy, halted, brk, overrun
    );

    modport slave (
        output opcode, start, resume, rom_data, cw_ack,
        input  rom_rd, rom_addr, control_word, cw_valid, step, busy, halted, brk, overrun
    );
endinterface
`default_nettype wire

// File: rtl/cword_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cword_assembler                                              |
// | Description : Byte-lane capture into a 32-bit shadow word with per-lane    |
// |               valid flags; flags completion on the final lane.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cword_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cap_en,
    input  logic [1:0]  i_cap_sel,
    input  logic [7:0]  i_rom_data,
    output logic [31:0] o_word,
    output logic        o_done
);
    logic [31:0] r_shadow;
    logic [3:0]  r_lane_vld;
    logic [31:0] w_merged;
    logic [3:0]  w_lane_bit;

    always_comb begin
        w_merged                          = r_shadow;
        w_merged[{i_cap_sel, 3'b000} +: 8] = i_rom_data;
        w_lane_bit                        = 4'b0001 << i_cap_sel;
    end

    // Lane 0 opens a new word, so stale flags from an aborted fetch are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow   <= '0;
            r_lane_vld <= '0;
        end else if (i_cap_en) begin
            r_shadow   <= w_merged;
            r_lane_vld <= (i_cap_sel == 2'd0) ? 4'b0001 : (r_lane_vld | w_lane_bit);
        end
    end

    assign o_word = w_merged;
    assign o_done = i_cap_en && (i_cap_sel == 2'd3) && (&r_lane_vld[2:0]);
endmodule
`default_nettype wire

// File: rtl/cword_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cword_sequencer                                              |
// | Description : Microcode fetch-and-step engine producing one 32-bit control |
// |               word per micro-step from a byte-wide synchronous ROM.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cword_sequencer
    import cword_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int STEP_W   = 3,
    parameter int ADDR_W   = OPCODE_W + STEP_W + c_addr_overhead
) (
    input  logic              clk,
    input  logic              rst,
    cword_sequencer_if.master bus
);
    state_t              r_state, w_state_nxt;
    logic [OPCODE_W-1:0] r_opcode;
    logic [STEP_W-1:0]   r_step, w_step_nxt;
    logic                r_ext, w_ext_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic [2:0]          r_cnt;
    logic [31:0]         r_cw;
    logic                r_cap_en;
    logic [1:0]          r_cap_sel;
    logic                w_rd;
    logic                w_take;
    logic [31:0]         w_word;
    logic                w_cw_done;

    cword_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .i_cap_en   (r_cap_en),
        .i_cap_sel  (r_cap_sel),
        .i_rom_data (bus.rom_data),
        .o_word     (w_word),
        .o_done     (w_cw_done)
    );

    assign w_rd = (r_state == S_FETCH) && !r_cnt[2];

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_ext_nxt     = r_ext;
        w_overrun_nxt = r_overrun;
        w_take        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_FETCH;
                    w_step_nxt  = '0;
                    w_ext_nxt   = 1'b0;
                end
            end
            S_FETCH: begin
                if (w_cw_done) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (bus.cw_ack) begin
                    if (r_cw[c_bit_halt])     w_state_nxt = S_HALT;
                    else if (r_cw[c_bit_brk]) w_state_nxt = S_BREAK;
                    else                      w_take      = 1'b1;
                end
            end
            S_BREAK: begin
                // The held word still carries the deferred step action
                if (bus.resume) w_take = 1'b1;
            end
            default: w_state_nxt = r_state;
        endcase

        if (w_take) begin
            if (!r_cw[c_bit_step_resetn]) begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = '0;
                w_ext_nxt   = 1'b0;
            end else begin
                w_state_nxt = S_FETCH;
                w_step_nxt  = r_step + 1'b1;
                if (!r_cw[c_bit_step_extn]) w_ext_nxt     = 1'b1;
                if (&r_step)                w_overrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_opcode  <= '0;
            r_step    <= '0;
            r_ext     <= 1'b0;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
            r_cw      <= '0;
            r_cap_en  <= 1'b0;
            r_cap_sel <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_ext     <= w_ext_nxt;
            r_overrun <= w_overrun_nxt;
            r_cap_en  <= w_rd;
            r_cap_sel <= r_cnt[1:0];
            if (r_state == S_IDLE && bus.start) r_opcode <= bus.opcode;
            if (r_state == S_FETCH && r_cnt != c_fetch_last) r_cnt <= r_cnt + 3'd1;
            else                                             r_cnt <= '0;
            if (w_cw_done) r_cw <= w_word;
        end
    end

    assign bus.rom_rd       = w_rd;
    assign bus.rom_addr     = w_rd ? ADDR_W'({r_ext, r_opcode, r_step, r_cnt[c_sel_w-1:0]}) : '0;
    assign bus.control_word = r_cw;
    assign bus.cw_valid     = (r_state == S_EXEC);
    assign bus.step         = r_step;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.halted       = (r_state == S_HALT);
    assign bus.brk          = (r_state == S_BREAK);
    assign bus.overrun      = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_cword_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cword_sequencer                                           |
// | Description : Randomized self-checking bench with a transaction-level      |
// |               model of the sequencer and a byte-wide ROM model.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_cword_sequencer;
    localparam int OPCODE_W = 8;
    localparam int STEP_W   = 3;
    localparam int ADDR_W   = OPCODE_W + STEP_W + 3;

    logic clk = 1'b0;
    logic rst;

    cword_sequencer_if #(.OPCODE_W(OPCODE_W), .STEP_W(STEP_W), .ADDR_W(ADDR_W)) bus ();

    cword_sequencer #(.OPCODE_W(OPCODE_W), .STEP_W(STEP_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:16383];

    // Data is valid the cycle after the read; garbage otherwise
    always @(posedge clk) bus.rom_data <= bus.rom_rd ? mem[bus.rom_addr] : 8'($urandom);

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Architectural model state
    logic [7:0]  m_op;
    logic [2:0]  m_step;
    logic        m_ext;
    logic        m_over;
    logic [31:0] m_cw;
    int          force_brk_wait = -1;
    logic [31:0] lit_addr_q[$];
    logic [31:0] lit_cw_q[$];

    // Expected outputs for the current cycle
    logic              e_rd, e_valid, e_busy, e_halted, e_brk, e_over;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_cw;
    logic [2:0]        e_step;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h want 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_rd", 32'(bus.rom_rd), 32'(e_rd));
            if (e_rd) chk("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
            chk("cw_valid", 32'(bus.cw_valid), 32'(e_valid));
            chk("control_word", bus.control_word, e_cw);
            chk("step", 32'(bus.step), 32'(e_step));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("halted", 32'(bus.halted), 32'(e_halted));
            chk("brk", 32'(bus.brk), 32'(e_brk));
            chk("overrun", 32'(bus.overrun), 32'(e_over));
        end
    end

    function automatic logic [ADDR_W-1:0] addr_of(input logic ext, input logic [7:0] op,
                                                   input logic [2:0] st, input int k);
        return {ext, op, st, 2'(k)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cw = '0; m_step = '0; m_ext = 1'b0; m_over = 1'b0;
    endtask

    task automatic set_exp(input logic rd, input logic [ADDR_W-1:0] addr,
                           input logic valid, input logic busy, input logic halted, input logic brk);
        e_rd = rd; e_addr = addr; e_valid = valid; e_busy = busy; e_halted = halted; e_brk = brk;
        e_cw = m_cw; e_step = m_step; e_over = m_over;
    endtask

    task automatic idle_cycle(input bit do_start, input logic [7:0] op);
        set_exp(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en      = 1'b1;
        bus.start   = do_start;
        bus.opcode  = do_start ? op : 8'($urandom);
        bus.resume  = 1'($urandom);
        bus.cw_ack  = 1'($urandom);
        cyc();
    endtask

    // Four reads then one capture cycle; abort_at asserts rst in that cycle
    task automatic fetch_phase(input int abort_at);
        logic [ADDR_W-1:0] a [4];
        for (int k = 0; k < 4; k++) a[k] = addr_of(m_ext, m_op, m_step, k);
        for (int k = 0; k < 5; k++) begin
            set_exp(k < 4, a[k % 4], 1'b0, 1'b1, 1'b0, 1'b0);
            bus.start  = 1'($urandom);
            bus.opcode = 8'($urandom);
            bus.resume = 1'($urandom);
            bus.cw_ack = 1'($urandom);
            if (k == 0 && lit_addr_q.size() > 0) chk("lit_addr", 32'(bus.rom_addr), lit_addr_q.pop_front());
            if (k == abort_at) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                model_reset();
                return;
            end
            cyc();
        end
        m_cw = {mem[a[3]], mem[a[2]], mem[a[1]], mem[a[0]]};
    endtask

    task automatic exec_phase(input int wait_n);
        for (int i = 0; i <= wait_n; i++) begin
            set_exp(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
            bus.start  = 1'($urandom);
            bus.opcode = 8'($urandom);
            bus.resume = 1'($urandom);
            bus.cw_ack = (i == wait_n);
            if (i == 0 && lit_cw_q.size() > 0) chk("lit_cw", bus.control_word, lit_cw_q.pop_front());
            cyc();
        end
    endtask

    task automatic break_phase(input int d);
        for (int i = 0; i <= d; i++) begin
            set_exp(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
            bus.start  = 1'($urandom);
            bus.opcode = 8'($urandom);
            bus.cw_ack = 1'($urandom);
            bus.resume = (i == d);
            cyc();
        end
    endtask

    // Halt absorbs every input; the final cycle carries rst
    task automatic halt_phase(input int n);
        for (int i = 0; i < n; i++) begin
            set_exp(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
            bus.start  = 1'b1;
            bus.opcode = 8'($urandom);
            bus.resume = 1'($urandom);
            bus.cw_ack = 1'($urandom);
            rst        = (i == n - 1);
            cyc();
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_instr(input logic [7:0] op);
        int  nsteps = 0;
        bit  done   = 1'b0;
        idle_cycle(1'b1, op);
        m_op = op; m_step = '0; m_ext = 1'b0;
        while (!done) begin
            if (nsteps >= 24) begin
                fetch_phase(0);
                done = 1'b1;
            end else begin
                fetch_phase(-1);
                exec_phase($urandom_range(0, 3));
                nsteps++;
                if (m_cw[26]) begin
                    halt_phase(12);
                    done = 1'b1;
                end else begin
                    if (m_cw[27]) break_phase(force_brk_wait >= 0 ? force_brk_wait : $urandom_range(0, 6));
                    if (!m_cw[24]) begin
                        m_step = '0; m_ext = 1'b0; done = 1'b1;
                    end else begin
                        if (!m_cw[25]) m_ext = 1'b1;
                        if (m_step == 3'd7) m_over = 1'b1;
                        m_step = m_step + 3'd1;
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] misc;
        logic [7:0] op;
        rst = 1'b1;
        bus.start = 1'b0; bus.resume = 1'b0; bus.cw_ack = 1'b0; bus.opcode = '0;
        model_reset();
        m_op = '0;
        set_exp(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16384; i++) begin
            if (i % 4 == 3) begin
                misc = 8'($urandom) & 8'hF2;
                if ($urandom_range(0, 3) != 0) misc = misc | 8'h01;
                if ($urandom_range(0, 7) == 0) misc = misc | 8'h08;
                mem[i] = misc;
            end else begin
                mem[i] = 8'($urandom);
            end
        end
        // opcode 0x12: advance with ext set, then step_resetn=0
        mem[addr_of(0, 8'h12, 3'd0, 0)] = 8'hAA;
        mem[addr_of(0, 8'h12, 3'd0, 1)] = 8'hBB;
        mem[addr_of(0, 8'h12, 3'd0, 2)] = 8'hCC;
        mem[addr_of(0, 8'h12, 3'd0, 3)] = 8'h01;
        mem[addr_of(1, 8'h12, 3'd1, 0)] = 8'h11;
        mem[addr_of(1, 8'h12, 3'd1, 1)] = 8'h22;
        mem[addr_of(1, 8'h12, 3'd1, 2)] = 8'h33;
        mem[addr_of(1, 8'h12, 3'd1, 3)] = 8'h00;
        // opcode 0x56: break with deferred advance, then reset
        mem[addr_of(0, 8'h56, 3'd0, 3)] = 8'h09;
        mem[addr_of(1, 8'h56, 3'd1, 3)] = 8'h00;
        // opcode 0x78: eight advancing steps wrap the counter
        for (int s = 0; s < 7; s++) mem[addr_of(0, 8'h78, 3'(s), 3)] = 8'h03;
        mem[addr_of(0, 8'h78, 3'd7, 3)] = 8'h01;
        mem[addr_of(1, 8'h78, 3'd0, 3)] = 8'h00;
        // opcode 0x9A: halt with step_resetn=0
        mem[addr_of(0, 8'h9A, 3'd0, 3)] = 8'h04;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_control_word", bus.control_word, 32'h0);
        chk("rst_rom_rd", 32'(bus.rom_rd), 32'h0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        chk("rst_cw_valid", 32'(bus.cw_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        idle_cycle(1'b0, 8'h00);

        lit_addr_q.push_back(32'h0240);
        lit_addr_q.push_back(32'h2244);
        lit_cw_q.push_back(32'h01CCBBAA);
        lit_cw_q.push_back(32'h00332211);
        run_instr(8'h12);
        chk("end_step", 32'(bus.step), 32'h0);
        idle_cycle(1'b0, 8'h00);

        // Reset while the third byte is being read
        idle_cycle(1'b1, 8'h34);
        m_op = 8'h34; m_step = '0; m_ext = 1'b0;
        fetch_phase(2);
        chk("abort_control_word", bus.control_word, 32'h0);
        chk("abort_rom_rd", 32'(bus.rom_rd), 32'h0);
        chk("abort_cw_valid", 32'(bus.cw_valid), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        idle_cycle(1'b0, 8'h00);

        force_brk_wait = 5;
        run_instr(8'h56);
        force_brk_wait = -1;

        chk("pre_wrap_overrun", 32'(bus.overrun), 32'h0);
        run_instr(8'h78);
        chk("wrap_overrun", 32'(bus.overrun), 32'h1);

        for (int n = 0; n < 40; n++) begin
            do op = 8'($urandom); while (op == 8'h9A);
            run_instr(op);
            repeat ($urandom_range(0, 2)) idle_cycle(1'b0, 8'h00);
        end

        run_instr(8'h9A);
        chk("post_halt_halted", 32'(bus.halted), 32'h0);
        chk("post_halt_overrun", 32'(bus.overrun), 32'h0);
        idle_cycle(1'b0, 8'h00);
        idle_cycle(1'b0, 8'h00);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
